// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and default constants for the fetch stage.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_t;

    localparam int unsigned PC_ADDR_W    = 32;
    localparam int unsigned PC_INC_STEP  = 4;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h8000_0180;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: exception > jump > branch > stall/halt hold > increment.
// Optional target alignment check under PC_ALIGN_CHK_EN.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int unsigned      ADDR_W   = PC_ADDR_W,
    parameter int unsigned      INC_STEP = PC_INC_STEP,
    parameter logic [ADDR_W-1:0] EXC_VEC = ADDR_W'(PC_EXC_VEC)
) (
    input  pc_state_t           state_i,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                stall_i,
    input  logic                branch_i,
    input  logic [ADDR_W-1:0]   branch_tgt_i,
    input  logic                jump_i,
    input  logic [ADDR_W-1:0]   jump_tgt_i,
    input  logic                exc_i,
    input  logic                halt_i,
    output logic [ADDR_W-1:0]   pc_inc_c,
    output logic [ADDR_W-1:0]   pc_c,
    output logic                epc_load_c,
    output logic [ADDR_W-1:0]   epc_c,
    output logic                misalign_c
);

    logic [ADDR_W-1:0] tgt;
    logic              bad_tgt;

    assign pc_inc_c = pc_i + ADDR_W'(INC_STEP);

    always_comb begin
        tgt        = jump_i ? jump_tgt_i : branch_tgt_i;
        bad_tgt    = 1'b0;
`ifdef PC_ALIGN_CHK_EN
        bad_tgt    = (jump_i || branch_i) && (tgt[1:0] != 2'b00);
`endif
        pc_c       = pc_i;
        epc_load_c = 1'b0;
        epc_c      = pc_i;
        misalign_c = 1'b0;
        case (state_i)
            PC_RUN: begin
                if (exc_i) begin
                    pc_c       = EXC_VEC;
                    epc_load_c = 1'b1;
                end else if (bad_tgt) begin
                    // Misaligned redirect is turned into an exception on the target
                    pc_c       = EXC_VEC;
                    epc_load_c = 1'b1;
                    epc_c      = tgt;
                    misalign_c = 1'b1;
                end else if (jump_i || branch_i) begin
                    pc_c = tgt;
                end else if (!(stall_i || halt_i)) begin
                    pc_c = pc_inc_c;
                end
            end
            PC_HALT: begin
                if (exc_i) begin
                    pc_c       = EXC_VEC;
                    epc_load_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Clocked MIPS fetch program counter with BOOT/RUN/HALT control and EPC capture.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHK_EN.
module pc_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W    = PC_ADDR_W,
    parameter int unsigned       INC_STEP  = PC_INC_STEP,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PC_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(PC_EXC_VEC)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                branch_i,
    input  logic [ADDR_W-1:0]   branch_tgt_i,
    input  logic                jump_i,
    input  logic [ADDR_W-1:0]   jump_tgt_i,
    input  logic                exc_i,
    input  logic                halt_i,
    input  logic                resume_i,
    output logic [ADDR_W-1:0]   pc_o,
    output logic [ADDR_W-1:0]   pc_next_o,
    output logic                pc_valid_o,
    output logic [ADDR_W-1:0]   epc_o
`ifdef PC_ALIGN_CHK_EN
    ,
    output logic                misalign_o
`endif
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_sel_c, epc_sel_c, pc_inc_c;
    logic              epc_load_c, misalign_c;

    pc_next_sel #(
        .ADDR_W   (ADDR_W),
        .INC_STEP (INC_STEP),
        .EXC_VEC  (EXC_VEC)
    ) u_sel (
        .state_i      (state_q),
        .pc_i         (pc_q),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .branch_tgt_i (branch_tgt_i),
        .jump_i       (jump_i),
        .jump_tgt_i   (jump_tgt_i),
        .exc_i        (exc_i),
        .halt_i       (halt_i),
        .pc_inc_c     (pc_inc_c),
        .pc_c         (pc_sel_c),
        .epc_load_c   (epc_load_c),
        .epc_c        (epc_sel_c),
        .misalign_c   (misalign_c)
    );

    // Next-state: exceptions (real or misalign traps) keep the unit running
    always_comb begin
        state_d = state_q;
        pc_d    = pc_sel_c;
        epc_d   = epc_load_c ? epc_sel_c : epc_q;
        case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN:  if (halt_i && !exc_i && !misalign_c) state_d = PC_HALT;
            PC_HALT: if (resume_i || exc_i) state_d = PC_RUN;
            default: state_d = PC_BOOT;
        endcase
        valid_d = (state_d == PC_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PC_BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            valid_q <= valid_d;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_c;
    end

    assign misalign_o = misalign_q;
`endif

    assign pc_o       = pc_q;
    assign pc_next_o  = pc_inc_c;
    assign pc_valid_o = valid_q;
    assign epc_o      = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then random traffic against a behavioural model.
// Honours PC_ALIGN_CHK_EN for the misalign port and trap behaviour.
module tb_pc_unit;

    localparam logic [31:0] EXC = 32'h8000_0180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] epc;
        logic        valid;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, branch_i, jump_i, exc_i, halt_i, resume_i;
    logic [31:0] branch_tgt_i, jump_tgt_i;
    logic [31:0] pc_o, pc_next_o, epc_o;
    logic        pc_valid_o;
    logic        mis_obs;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t exp_q[$];

    // Model state: mode 0 = booting, 1 = fetching, 2 = halted
    int          m_mode;
    logic [31:0] m_pc, m_epc;
    logic        m_mis;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .branch_i     (branch_i),
        .branch_tgt_i (branch_tgt_i),
        .jump_i       (jump_i),
        .jump_tgt_i   (jump_tgt_i),
        .exc_i        (exc_i),
        .halt_i       (halt_i),
        .resume_i     (resume_i),
        .pc_o         (pc_o),
        .pc_next_o    (pc_next_o),
        .pc_valid_o   (pc_valid_o),
        .epc_o        (epc_o)
`ifdef PC_ALIGN_CHK_EN
        ,
        .misalign_o   (mis_obs)
`endif
    );

`ifndef PC_ALIGN_CHK_EN
    assign mis_obs = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_epc  = 32'h0;
        m_mis  = 1'b0;
    endtask

    // Advance the model by one clock edge from the given inputs
    task automatic model_step(input logic s, input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic e, input logic h, input logic r);
        logic [31:0] tgt;
        logic        bad;
        m_mis = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            tgt = j ? jt : bt;
            bad = 1'b0;
`ifdef PC_ALIGN_CHK_EN
            bad = (j || b) && (tgt % 4 != 0);
`endif
            if (e) begin
                m_epc = m_pc;
                m_pc  = EXC;
            end else if (bad) begin
                m_epc = tgt;
                m_pc  = EXC;
                m_mis = 1'b1;
            end else if (j || b) begin
                m_pc = tgt;
            end else if (!(s || h)) begin
                m_pc = m_pc + 32'd4;
            end
            if (h && !e && !bad) m_mode = 2;
        end else begin
            if (e) begin
                m_epc  = m_pc;
                m_pc   = EXC;
                m_mode = 1;
            end else if (r) begin
                m_mode = 1;
            end
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge) and queue the expected result
    task automatic step(input logic s, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt,
                        input logic e, input logic h, input logic r);
        exp_t x;
        stall_i = s; branch_i = b; branch_tgt_i = bt;
        jump_i = j; jump_tgt_i = jt; exc_i = e; halt_i = h; resume_i = r;
        model_step(s, b, bt, j, jt, e, h, r);
        x.pc      = m_pc;
        x.pc_next = m_pc + 32'd4;
        x.epc     = m_epc;
        x.valid   = (m_mode == 1);
        x.mis     = m_mis;
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic goto(input logic [31:0] a);
        step(0, 0, 32'h0, 1, a, 0, 0, 0);
    endtask

    task automatic check_reset_state();
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", 32'(pc_valid_o), 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_mis", 32'(mis_obs), 32'h0);
    endtask

    // Monitor: every clock edge yields one fetch-PC observation to score
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("pc", pc_o, x.pc);
                chk("pc_next", pc_next_o, x.pc_next);
                chk("epc", epc_o, x.epc);
                chk("valid", 32'(pc_valid_o), 32'(x.valid));
`ifdef PC_ALIGN_CHK_EN
                chk("misalign", 32'(mis_obs), 32'(x.mis));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        stall_i = 0; branch_i = 0; jump_i = 0; exc_i = 0; halt_i = 0; resume_i = 0;
        branch_tgt_i = 0; jump_tgt_i = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state();
        rst_n = 1'b1;
        #1 check_reset_state();

        // Boot then sequential fetch 0,4,8
        idle(); idle(); idle();
        // Stall hold
        goto(32'h10);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Redirect beats stall; jump beats branch
        goto(32'h20);
        step(1, 1, 32'h100, 0, 0, 0, 0, 0);
        goto(32'h20);
        step(0, 1, 32'h104, 1, 32'h200, 0, 0, 0);
        // Exception beats jump
        goto(32'h40);
        step(0, 0, 0, 1, 32'h300, 1, 0, 0);
        idle();
        // Halt, ignored redirects, halt+resume, then exception out of halt
        goto(32'h50);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 32'h120, 1, 32'h220, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        // Halt together with a redirect: target applied, resumed from it
        step(0, 0, 0, 1, 32'h400, 0, 1, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        // Increment wrap and misaligned branch
        goto(32'hFFFF_FFFC);
        idle();
        step(0, 1, 32'h102, 0, 0, 0, 0, 0);
        idle();
        // Exception in RUN wins over halt
        step(0, 0, 0, 0, 0, 1, 1, 0);
        idle();

        // Reset mid-operation discards a pending jump
        jump_i = 1'b1; jump_tgt_i = 32'h700;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_state();
        @(negedge clk);
        jump_i = 1'b0; jump_tgt_i = 32'h0;
        rst_n = 1'b1;
        idle(); idle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), bt,
                 ($urandom_range(0, 7) == 0), jt, ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
